// File: rtl/rabbit_stream_xor_pkg.sv
// Shared constants, FSM encoding and helpers for the Rabbit keystream XOR datapath.
package rabbit_stream_xor_pkg;

    localparam int BLK_W            = 128;
    localparam int BLK_BYTES        = BLK_W / 8;
    localparam int WARMUP_ITERS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Non-last beats are always full; out-of-range counts on a last beat mean full too.
    function automatic logic [4:0] eff_bytes(input logic last, input logic [4:0] bytes);
        if (!last || bytes == 5'd0 || bytes > 5'd16) begin
            return 5'd16;
        end
        return bytes;
    endfunction

endpackage

// File: rtl/rabbit_stream_xor_if.sv
// Keystream-generator strobes plus input/output beat streams of the XOR engine.
interface rabbit_stream_xor_if;
    import rabbit_stream_xor_pkg::*;

    logic             ks_load;
    logic             ks_en;
    logic [BLK_W-1:0] ks_word;
    logic             ks_done;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             in_last;
    logic [4:0]       in_bytes;

    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic             out_last;
    logic [4:0]       out_bytes;

    modport slave (
        output ks_load, ks_en, in_ready, out_valid, out_data, out_last, out_bytes,
        input  ks_word, ks_done, in_valid, in_data, in_last, in_bytes, out_ready
    );

    modport master (
        input  ks_load, ks_en, in_ready, out_valid, out_data, out_last, out_bytes,
        output ks_word, ks_done, in_valid, in_data, in_last, in_bytes, out_ready
    );

endinterface

// File: rtl/rabbit_stream_xor_byte_mask.sv
// Byte-count to block mask; byte 0 sits in the most significant byte lane.
module rabbit_byte_mask
    import rabbit_stream_xor_pkg::*;
(
    input  logic [4:0]       bytes_i,
    output logic [BLK_W-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (5'(i) < bytes_i) begin
                mask_o[BLK_W-1-8*i -: 8] = 8'hFF;
            end
        end
    end

endmodule

// File: rtl/rabbit_stream_xor.sv
// Session sequencer and XOR datapath between an input beat stream and a keystream generator.
//   state | meaning
//   IDLE  | waiting for start, blk_count holds last session total
//   LOAD  | one-cycle ks_load, blk_count cleared
//   WARM  | ks_en for WARMUP_ITERS cycles to warm the generator
//   RUN   | accepting beats, one ks_en per accepted beat
//   DRAIN | last beat accepted, waiting for it to leave the output register
module rabbit_stream_xor
    import rabbit_stream_xor_pkg::*;
#(
    parameter int WARMUP_ITERS = WARMUP_ITERS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic [31:0]         blk_count_o,
    rabbit_stream_xor_if.slave  bus
);

    state_e           state_q, state_d;
    logic [2:0]       warm_cnt_q, warm_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [BLK_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [4:0]       out_bytes_q, out_bytes_d;
    logic [31:0]      blk_count_q, blk_count_d;

    logic [4:0]       eff_bytes_w;
    logic [BLK_W-1:0] mask_w;
    logic             accept;

    assign eff_bytes_w = eff_bytes(bus.in_last, bus.in_bytes);

    rabbit_byte_mask u_mask (
        .bytes_i (eff_bytes_w),
        .mask_o  (mask_w)
    );

    // Reset gates every strobe so an in-flight beat is dropped without side effects.
    assign bus.in_ready = !rst && (state_q == ST_RUN) && bus.ks_done
                          && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.ks_load  = !rst && (state_q == ST_LOAD);
    assign bus.ks_en    = !rst && ((state_q == ST_WARM) || accept);

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        blk_count_d = blk_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_bytes_d = out_bytes_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                warm_cnt_d  = 3'(WARMUP_ITERS - 1);
                blk_count_d = '0;
                state_d     = ST_WARM;
            end
            ST_WARM: begin
                if (warm_cnt_q == 3'd0) state_d = ST_RUN;
                else                    warm_cnt_d = warm_cnt_q - 3'd1;
            end
            ST_RUN: begin
                if (accept && bus.in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_valid_q && bus.out_ready && out_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = (bus.in_data ^ bus.ks_word) & mask_w;
            out_last_d  = bus.in_last;
            out_bytes_d = eff_bytes_w;
            blk_count_d = blk_count_q + 32'd1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            warm_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_bytes_q <= '0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_bytes_q <= out_bytes_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_bytes = out_bytes_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign blk_count_o   = blk_count_q;

endmodule

// File: tb/tb_rabbit_stream_xor.sv
// Self-checking bench: stub keystream generator plus a byte-level reference model of the XOR stream.
module tb_rabbit_stream_xor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic [31:0] blk_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [4:0]   bytes;
    } beat_t;

    rabbit_stream_xor_if bif ();

    rabbit_stream_xor dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .busy_o      (busy),
        .blk_count_o (blk_count),
        .bus         (bif)
    );

    always #5 clk = ~clk;

    // Stub generator: done after 4 advances post-load, then word index n counts further advances.
    int          ks_pulses;
    logic        ks_done_r;
    logic [31:0] ks_n;

    always_ff @(posedge clk) begin
        if (rst || bif.ks_load) begin
            ks_pulses <= 0;
            ks_done_r <= 1'b0;
            ks_n      <= 32'd0;
        end else if (bif.ks_en) begin
            if (!ks_done_r) begin
                if (ks_pulses == 3) ks_done_r <= 1'b1;
                ks_pulses <= ks_pulses + 1;
            end else begin
                ks_n <= ks_n + 32'd1;
            end
        end
    end

    assign bif.ks_done = ks_done_r;
    assign bif.ks_word = {4{32'hA5A50000 + ks_n}};

    function automatic int model_bytes(input bit last, input int nb);
        if (!last || nb == 0 || nb > 16) return 16;
        return nb;
    endfunction

    function automatic logic [127:0] model_data(input logic [127:0] d, input int k,
                                                input bit last, input int nb);
        logic [127:0] r;
        int           eb;
        r  = d ^ {4{32'hA5A50000 + 32'(k)}};
        eb = model_bytes(last, nb);
        for (int i = eb; i < 16; i++) r[127-8*i -: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [127:0] make_data(input int mode);
        if (mode == 0) return '0;
        if (mode == 1) return '1;
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); end
        checks++; if (bif.out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bif.out_data); end
        checks++; if (bif.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", bif.out_last); end
        checks++; if (bif.out_bytes !== 5'd0) begin errors++; $display("FAIL reset_out_bytes: got %0d expected 0", bif.out_bytes); end
        checks++; if (blk_count !== 32'd0) begin errors++; $display("FAIL reset_blk_count: got %0d expected 0", blk_count); end
        checks++; if (bif.ks_load !== 1'b0) begin errors++; $display("FAIL reset_ks_load: got %b expected 0", bif.ks_load); end
        checks++; if (bif.ks_en !== 1'b0) begin errors++; $display("FAIL reset_ks_en: got %b expected 0", bif.ks_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bif.in_ready); end
    endtask

    // Start sampled at cycle 0; leaves the bench mid-cycle 6 with the DUT in RUN.
    task automatic open_session(input bit chk);
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (chk) begin
                checks++; if (bif.ks_load !== (c == 1)) begin errors++; $display("FAIL start_ks_load cycle %0d: got %b expected %b", c, bif.ks_load, (c == 1)); end
                checks++; if (bif.ks_en !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL start_ks_en cycle %0d: got %b expected %b", c, bif.ks_en, (c >= 2 && c <= 5)); end
                checks++; if (bif.in_ready !== (c == 6)) begin errors++; $display("FAIL start_in_ready cycle %0d: got %b expected %b", c, bif.in_ready, (c == 6)); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy cycle %0d: got %b expected 1", c, busy); end
            end
            if (c < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic stream_beats(input int nbeats, input int mode, input int last_bytes,
                                input int rdy_pct, input int vld_pct);
        beat_t        q[$];
        beat_t        e;
        logic [127:0] cur;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        bit           in_run = 1'b1;
        bit           exp_rdy;
        bit           acc;
        bit           lst;
        cur = make_data(mode);
        while (got < nbeats && cyc < 400) begin
            lst = (sent == nbeats - 1);
            bif.in_valid  = (sent < nbeats) && ($urandom_range(99) < vld_pct);
            bif.in_data   = cur;
            bif.in_last   = lst;
            bif.in_bytes  = lst ? 5'(last_bytes) : 5'($urandom_range(31));
            bif.out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            exp_rdy = in_run && (q.size() == 0 || bif.out_ready);
            acc     = bif.in_valid && exp_rdy;
            checks++; if (bif.in_ready !== exp_rdy) begin errors++; $display("FAIL stream_in_ready beat %0d: got %b expected %b", sent, bif.in_ready, exp_rdy); end
            checks++; if (bif.ks_en !== acc) begin errors++; $display("FAIL stream_ks_en beat %0d: got %b expected %b", sent, bif.ks_en, acc); end
            checks++; if (bif.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL stream_out_valid: got %b expected %b", bif.out_valid, (q.size() != 0)); end
            if (q.size() != 0 && bif.out_ready) begin
                e = q.pop_front();
                checks++; if (bif.out_data !== e.data) begin errors++; $display("FAIL stream_out_data beat %0d: got %h expected %h", got, bif.out_data, e.data); end
                checks++; if (bif.out_last !== e.last) begin errors++; $display("FAIL stream_out_last beat %0d: got %b expected %b", got, bif.out_last, e.last); end
                checks++; if (bif.out_bytes !== e.bytes) begin errors++; $display("FAIL stream_out_bytes beat %0d: got %0d expected %0d", got, bif.out_bytes, e.bytes); end
                got++;
            end
            if (acc) begin
                e.data  = model_data(cur, sent, lst, last_bytes);
                e.last  = lst;
                e.bytes = 5'(model_bytes(lst, last_bytes));
                q.push_back(e);
                if (lst) in_run = 1'b0;
                sent++;
                cur = make_data(mode);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) begin
            errors++; $display("FAIL stream_timeout: got %0d beats expected %0d", got, nbeats);
        end
        bif.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL end_busy: got %b expected 0", busy); end
            checks++; if (blk_count !== 32'(nbeats)) begin errors++; $display("FAIL end_blk_count: got %0d expected %0d", blk_count, nbeats); end
            checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL end_out_valid: got %b expected 0", bif.out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_startup_and_zero_blocks();
        open_session(1'b1);
        stream_beats(3, 0, 16, 100, 100);
    endtask

    task automatic test_partial_last();
        open_session(1'b0);
        stream_beats(2, 1, 5, 100, 100);
    endtask

    task automatic test_backpressure();
        logic [127:0] d0, d1, e0, e1;
        open_session(1'b0);
        d0 = make_data(2);
        d1 = make_data(2);
        e0 = model_data(d0, 0, 1'b0, 16);
        e1 = model_data(d1, 1, 1'b1, 16);
        bif.in_valid = 1'b1; bif.in_data = d0; bif.in_last = 1'b0; bif.in_bytes = 5'd16;
        bif.out_ready = 1'b1;
        #1;
        checks++; if (bif.ks_en !== 1'b1) begin errors++; $display("FAIL bp_first_ks_en: got %b expected 1", bif.ks_en); end
        @(posedge clk); #1;
        bif.in_data = d1; bif.in_last = 1'b1; bif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bif.out_data !== e0) begin errors++; $display("FAIL bp_hold_data stall %0d: got %h expected %h", i, bif.out_data, e0); end
            checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid stall %0d: got %b expected 1", i, bif.out_valid); end
            checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready stall %0d: got %b expected 0", i, bif.in_ready); end
            checks++; if (bif.ks_en !== 1'b0) begin errors++; $display("FAIL bp_ks_en stall %0d: got %b expected 0", i, bif.ks_en); end
            @(posedge clk); #1;
        end
        bif.out_ready = 1'b1;
        #1;
        checks++; if (bif.out_data !== e0) begin errors++; $display("FAIL bp_release_data: got %h expected %h", bif.out_data, e0); end
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bif.in_ready); end
        checks++; if (bif.ks_en !== 1'b1) begin errors++; $display("FAIL bp_release_ks_en: got %b expected 1", bif.ks_en); end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        #1;
        checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", bif.out_valid); end
        checks++; if (bif.out_data !== e1) begin errors++; $display("FAIL bp_second_data: got %h expected %h", bif.out_data, e1); end
        checks++; if (bif.out_last !== 1'b1) begin errors++; $display("FAIL bp_second_last: got %b expected 1", bif.out_last); end
        @(posedge clk); #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_emit: got %b expected 0", bif.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", busy); end
        checks++; if (blk_count !== 32'd2) begin errors++; $display("FAIL bp_blk_count: got %0d expected 2", blk_count); end
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 8; s++) begin
            open_session(1'b0);
            stream_beats($urandom_range(1, 6), 2, $urandom_range(0, 31), 60, 70);
        end
    endtask

    task automatic test_start_and_reset();
        open_session(1'b0);
        bif.in_valid = 1'b1; bif.in_data = make_data(2); bif.in_last = 1'b0; bif.in_bytes = 5'd16;
        bif.out_ready = 1'b0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bif.ks_load !== 1'b0) begin errors++; $display("FAIL run_start_ks_load cycle %0d: got %b expected 0", i, bif.ks_load); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_start_busy cycle %0d: got %b expected 1", i, busy); end
            checks++; if (blk_count !== 32'd1) begin errors++; $display("FAIL run_start_blk_count cycle %0d: got %0d expected 1", i, blk_count); end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        #1;
        checks++; if (bif.ks_en !== 1'b0) begin errors++; $display("FAIL rst_ks_en: got %b expected 0", bif.ks_en); end
        checks++; if (bif.ks_load !== 1'b0) begin errors++; $display("FAIL rst_ks_load: got %b expected 0", bif.ks_load); end
        checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bif.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        bif.in_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bif.out_valid); end
        checks++; if (blk_count !== 32'd0) begin errors++; $display("FAIL rst_blk_count: got %0d expected 0", blk_count); end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.in_last   = 1'b0;
        bif.in_bytes  = 5'd0;
        bif.out_ready = 1'b0;
        test_reset();
        test_startup_and_zero_blocks();
        test_partial_last();
        test_backpressure();
        test_random_sessions();
        test_start_and_reset();
        test_startup_and_zero_blocks();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
